// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg -- shared constants and helpers for the counter scheduler.
// Holds the FSM state encoding, the count width and the round-robin
// arbitration helpers used by cnt_sched and cnt_core.
package cnt_sched_pkg;

  // Counter datapath width.
  localparam int CNT_W = 8;

  // FSM state encoding (kept as plain constants for legacy compatibility).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Round-robin pick: a lone requester always wins; on a tie the
  // requester that was not granted last time wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

  // Requester index to one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    logic [1:0] oh;
    if (idx) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/cnt_core.sv
// cnt_core -- shared 8-bit counter datapath for cnt_sched.
// Synchronous load has priority over increment; the increment wraps
// modulo 2^CNT_W. rst is an asynchronous active-low clear.
module cnt_core
  import cnt_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_r;

  // Counter register: clear, load, increment or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {CNT_W{1'b0}};
    end else if (load) begin
      q_r <= din;
    end else if (en) begin
      q_r <= q_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched -- two-requester round-robin scheduler driving a shared counter.
// A granted job loads the requester's start value, counts up (wrapping)
// until the requester's end value, then pulses done for one cycle.
// Optional feature macro: CNT_SCHED_ABORT_EN adds the abort input, which
// cancels a job in LOAD or RUN without a done pulse.
module cnt_sched
  import cnt_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] start0,
  input  logic [CNT_W-1:0] end0,
  input  logic [CNT_W-1:0] start1,
  input  logic [CNT_W-1:0] end1,
`ifdef CNT_SCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             done_id
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [1:0]       gnt_r;
  logic [1:0]       gnt_nxt_s;
  logic             last_r;
  logic             last_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             done_id_r;
  logic             gidx_s;
  logic [CNT_W-1:0] start_sel_s;
  logic [CNT_W-1:0] end_sel_s;
  logic [CNT_W-1:0] cnt_s;
  logic             at_end_s;
  logic             abort_s;
  logic             load_s;
  logic             en_s;

`ifdef CNT_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // The grant register is one-hot, so bit 1 is the granted index.
  assign gidx_s      = gnt_r[1];
  assign start_sel_s = gidx_s ? start1 : start0;
  assign end_sel_s   = gidx_s ? end1 : end0;
  assign at_end_s    = (cnt_s == end_sel_s);

  // Next-state, grant, pointer and counter-control decode.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    last_nxt_s  = last_r;
    load_s      = 1'b0;
    en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        // req is only looked at here; a granted job is committed.
        if (req != 2'b00) begin
          state_nxt_s = LOAD;
          gnt_nxt_s   = idx_to_onehot(rr_pick(req, last_r));
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = 2'b00;
          last_nxt_s  = gidx_s;
        end else begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = 2'b00;
          last_nxt_s  = gidx_s;
        end else if (at_end_s) begin
          state_nxt_s = DONE;
        end else begin
          en_s        = 1'b1;
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        // abort is deliberately ignored here: the job has completed.
        state_nxt_s = IDLE;
        gnt_nxt_s   = 2'b00;
        last_nxt_s  = gidx_s;
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 2'b00;
      end
    endcase
  end

  // FSM state, grant and last-granted pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      gnt_r   <= 2'b00;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Registered status outputs, derived from the upcoming state so they
  // line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        done_id_r <= gidx_s;
      end else begin
        done_id_r <= done_id_r;
      end
    end
  end

  cnt_core u_cnt_core (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .en   (en_s),
    .din  (start_sel_s),
    .q    (cnt_s)
  );

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign cnt     = cnt_s;
  assign done    = done_r;
  assign done_id = done_id_r;

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched -- self-checking bench for cnt_sched.
// A job-level reference model turns each accepted request into the
// expected per-cycle trace (one LOAD cycle, ((end-start) mod 256)+1 RUN
// cycles, one DONE cycle) and compares it with the DUT every cycle.
// Build with CNT_SCHED_ABORT_EN defined to also exercise abort.
module tb_cnt_sched;

  typedef struct {
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] cnt;
    logic       done;
    int         ph;     // 0 idle, 1 load, 2 run, 3 done
    logic       w;      // requester owning this cycle
  } exp_t;

`ifdef CNT_SCHED_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] start0, end0, start1, end1;
`ifdef CNT_SCHED_ABORT_EN
  logic       abort_v;
`endif
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] cnt;
  logic       done;
  logic       done_id;

  int   n_vec;
  int   n_bad;
  exp_t exp_q[$];
  exp_t cur_e;
  logic [7:0] cnt_m;
  logic       done_id_m;
  logic       last_m;

  cnt_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .start0  (start0),
    .end0    (end0),
    .start1  (start1),
    .end1    (end1),
`ifdef CNT_SCHED_ABORT_EN
    .abort   (abort_v),
`endif
    .gnt     (gnt),
    .busy    (busy),
    .cnt     (cnt),
    .done    (done),
    .done_id (done_id)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.gnt  = 2'b00;
    e.busy = 1'b0;
    e.cnt  = cnt_m;
    e.done = 1'b0;
    e.ph   = 0;
    e.w    = 1'b0;
    return e;
  endfunction

  // Append the whole expected trace of a job granted from req r.
  task automatic push_job(input logic [1:0] r);
    logic       w;
    logic [7:0] s;
    logic [7:0] e;
    logic [7:0] c;
    int         n;
    exp_t       x;
    if (r == 2'b11) w = ~last_m;
    else            w = (r == 2'b10);
    s = w ? start1 : start0;
    e = w ? end1 : end0;
    n = int'(8'(e - s)) + 1;
    x.gnt  = w ? 2'b10 : 2'b01;
    x.busy = 1'b1;
    x.done = 1'b0;
    x.w    = w;
    x.ph   = 1;
    x.cnt  = cnt_m;
    exp_q.push_back(x);
    c = s;
    for (int i = 0; i < n; i++) begin
      x.ph  = 2;
      x.cnt = c;
      exp_q.push_back(x);
      c = c + 8'd1;
    end
    x.ph   = 3;
    x.cnt  = e;
    x.done = 1'b1;
    exp_q.push_back(x);
  endtask

  task automatic check_outputs();
    chk_val("gnt", 32'(gnt), 32'(cur_e.gnt));
    chk_val("busy", 32'(busy), 32'(cur_e.busy));
    chk_val("cnt", 32'(cnt), 32'(cur_e.cnt));
    chk_val("done", 32'(done), 32'(cur_e.done));
    if (cur_e.done) chk_val("done_id", 32'(done_id), 32'(cur_e.w));
  endtask

  // Drive one cycle of inputs, advance one edge, then compare.
  task automatic step(input logic [1:0] r, input logic ab);
    req = r;
`ifdef CNT_SCHED_ABORT_EN
    abort_v = ab;
`endif
    if (cur_e.ph == 0 && r != 2'b00) push_job(r);
    if (ABORT_ON && ab && (cur_e.ph == 1 || cur_e.ph == 2)) begin
      exp_q.delete();
      last_m = cur_e.w;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) cur_e = exp_q.pop_front();
    else                  cur_e = idle_exp();
    cnt_m = cur_e.cnt;
    if (cur_e.ph == 3) begin
      done_id_m = cur_e.w;
      last_m    = cur_e.w;
    end
    check_outputs();
  endtask

  task automatic model_reset();
    exp_q.delete();
    cnt_m     = 8'd0;
    done_id_m = 1'b0;
    last_m    = 1'b1;
    cur_e     = idle_exp();
  endtask

  // Hold reset across an edge, check reset values, release off-edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk_val("rst_done_id", 32'(done_id), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
  endtask

  // Step with req idle until the model reaches RUN with the given count.
  task automatic run_to(input logic [7:0] target);
    int k;
    k = 0;
    while (!(cur_e.ph == 2 && cur_e.cnt == target) && k < 300) begin
      step(2'b00, 1'b0);
      k++;
    end
    chk_val("run_to_timeout", 32'(k < 300), 32'd1);
  endtask

  // Main stimulus: directed scenarios then randomized traffic.
  initial begin
    logic [1:0] r;
    logic       ab;
    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    req    = 2'b00;
    start0 = 8'd0; end0 = 8'd0; start1 = 8'd0; end1 = 8'd0;
`ifdef CNT_SCHED_ABORT_EN
    abort_v = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Simple job for requester 0: cnt 3,4,5,6 then done.
    start0 = 8'd3; end0 = 8'd6;
    step(2'b01, 1'b0);
    repeat (8) step(2'b00, 1'b0);

    // Both requesting: grants alternate starting with requester 0.
    do_reset();
    start0 = 8'd1; end0 = 8'd2; start1 = 8'd5; end1 = 8'd5;
    repeat (18) step(2'b11, 1'b0);
    repeat (8) step(2'b00, 1'b0);

    // Wrapping job for requester 1: 250..255,0,1,2.
    start1 = 8'd250; end1 = 8'd2;
    step(2'b10, 1'b0);
    repeat (13) step(2'b00, 1'b0);

    // Minimum-length job: start equals end.
    start0 = 8'd7; end0 = 8'd7;
    step(2'b01, 1'b0);
    repeat (4) step(2'b00, 1'b0);

    // Reset in the middle of RUN, then a normal job afterwards.
    start0 = 8'd3; end0 = 8'd20;
    step(2'b01, 1'b0);
    run_to(8'd5);
    do_reset();
    start0 = 8'd9; end0 = 8'd11; start1 = 8'd40; end1 = 8'd41;
    step(2'b11, 1'b0);
    repeat (7) step(2'b00, 1'b0);

`ifdef CNT_SCHED_ABORT_EN
    // Abort at cnt=10, then the other requester wins the tie.
    start0 = 8'd5; end0 = 8'd30; start1 = 8'd60; end1 = 8'd62;
    step(2'b01, 1'b0);
    run_to(8'd10);
    step(2'b00, 1'b1);
    chk_val("abort_cnt_hold", 32'(cnt), 32'd10);
    step(2'b11, 1'b0);
    chk_val("abort_next_gnt", 32'(gnt), 32'd2);
    repeat (8) step(2'b00, 1'b0);
`endif

    // Randomized traffic; operands change only while idle.
    for (int i = 0; i < 3000; i++) begin
      if (cur_e.ph == 0) begin
        start0 = 8'($urandom);
        start1 = 8'($urandom);
        if ($urandom_range(0, 7) == 0) end0 = 8'($urandom);
        else                           end0 = 8'(start0 + 8'($urandom_range(0, 12)));
        if ($urandom_range(0, 7) == 0) end1 = 8'($urandom);
        else                           end1 = 8'(start1 + 8'($urandom_range(0, 12)));
      end
      r  = 2'($urandom_range(0, 3));
      ab = ABORT_ON && ($urandom_range(0, 15) == 0);
      step(r, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
